alu_sequencer: RTL and testbench

- Command-driven controller that sequences the 8-bit ALU datapath (input muxes, accumulator/input DFFs, logic/arith units, one-hot output mux).
- Queues ALU commands and drives in_selector, out_selector and operands in the load-then-execute order the datapath needs.
- Captures the result and the multiply overflow, and returns them through a valid/ready response port.
- Sits between the command source (test host or microsequencer) and the ALU datapath.

---
 rtl/alu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Command-driven controller for the 8-bit ALU datapath. Commands are queued,
// popped one at a time, and sequenced as LOAD (operands into the datapath
// input registers) followed by EXEC (one-hot op on the output mux, result
// captured). The result and the multiply overflow are returned on a
// valid/ready response port. An overflowing MUL or a reserved opcode raises a
// sticky error that halts popping until clr_err.
//
// Optional build macro: ALU_SEQ_STATS_EN adds op_count / err_count outputs.
//
// Ports
//   clk, rst         clock, synchronous active-low reset
//   on               enable; low parks the FSM in OFF after the current command
//   cmd_*            command push interface (valid/ready), op, chain, a, b
//   res_*            response interface (valid/ready), data, per-result error
//   err_flag         sticky error; clr_err clears it and leaves ERR
//   alu_in_sel       datapath in_selector  {persist, load, reset}
//   alu_out_sel      datapath out_selector {MUL,SUB,ADD,XOR,NOT,OR,AND}
//   alu_num1/2       datapath operands
//   alu_result/ovf   datapath output value and multiply overflow
//   state            current FSM state (debug)
//   op_count         [stats] responses delivered
//   err_count        [stats] error responses delivered, saturating
// -----------------------------------------------------------------------------
module alu_sequencer #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          on,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic          cmd_chain,
   input  logic [W-1:0]  cmd_a,
   input  logic [W-1:0]  cmd_b,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [W-1:0]  res_data,
   output logic          res_err,
   output logic          err_flag,
   input  logic          clr_err,
   output logic [2:0]    alu_in_sel,
   output logic [6:0]    alu_out_sel,
   output logic [W-1:0]  alu_num1,
   output logic [W-1:0]  alu_num2,
   input  logic [W-1:0]  alu_result,
   input  logic          alu_ovf,
   output logic [2:0]    state
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0]   op_count,
   output logic [7:0]    err_count
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = 3 + 1 + 2 * W;

   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_RSV = 3'd7;

   // in_selector encodings; "hold" (no selector) keeps the datapath
   // registers untouched between commands so a chained command can still
   // pick up the previous result.
   localparam logic [2:0] IN_HOLD    = 3'b000;
   localparam logic [2:0] IN_RESET   = 3'b001;
   localparam logic [2:0] IN_LOAD    = 3'b010;
   localparam logic [2:0] IN_PERSIST = 3'b100;

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_IDLE = 3'd1,
      ST_LOAD = 3'd2,
      ST_EXEC = 3'd3,
      ST_RESP = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   state_t state_q, state_d;

   // ---------------------------------------------------------------------
   // Command queue: storage array plus wrap-bit pointers
   // ---------------------------------------------------------------------
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          q_empty;
   logic          q_full;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   // Current command, captured from the queue head on pop
   logic [2:0]    cur_op_q, cur_op_d;
   logic          cur_chain_q, cur_chain_d;
   logic [W-1:0]  num1_q, num1_d;
   logic [W-1:0]  num2_q, num2_d;

   // Output-mux select and response registers
   logic [6:0]    out_sel_q, out_sel_d;
   logic [6:0]    op_onehot;
   logic [W-1:0]  res_data_q, res_data_d;
   logic          res_err_q, res_err_d;
   logic          err_flag_q, err_flag_d;
   logic          res_hs;

   assign q_empty = (wr_ptr_q == rd_ptr_q);
   assign q_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // cmd_ready depends only on registered state, so a pop out of a full
   // queue does not open a slot until the following cycle.
   assign push   = cmd_valid && cmd_ready;
   assign pop    = (state_q == ST_IDLE) && on && !q_empty && !err_flag_q;
   assign res_hs = (state_q == ST_RESP) && res_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_chain, cmd_a, cmd_b};
      end
   end

   // The head is read asynchronously but only consumed through the
   // cur_* registers, so every datapath-facing value is registered.
   assign head = mem_q[rd_ptr_q[AW-1:0]];

   // One-hot decode of the current op; the reserved op decodes to all zeros.
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_onehot
         assign op_onehot[gi] = (cur_op_q == 3'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OFF: begin
            if (on) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (!on)      state_d = ST_OFF;
            else if (pop) state_d = ST_LOAD;
         end
         ST_LOAD: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            if (res_hs) begin
               if (res_err_q) state_d = ST_ERR;
               else if (!on)  state_d = ST_OFF;
               else           state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            if (clr_err) state_d = ST_IDLE;
         end
         default: state_d = ST_OFF;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      alu_in_sel = IN_HOLD;
      res_valid  = 1'b0;
      cmd_ready  = on && !q_full && (state_q != ST_OFF);
      unique case (state_q)
         ST_OFF:  alu_in_sel = IN_RESET;
         ST_LOAD: alu_in_sel = cur_chain_q ? IN_PERSIST : IN_LOAD;
         ST_EXEC: alu_in_sel = IN_PERSIST;
         ST_RESP: res_valid  = 1'b1;
         default: alu_in_sel = IN_HOLD;
      endcase
   end

   // ---------------------------------------------------------------------
   // Queue pointers, command registers, response capture
   // ---------------------------------------------------------------------
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cur_op_d    = cur_op_q;
      cur_chain_d = cur_chain_q;
      num1_d      = num1_q;
      num2_d      = num2_q;
      out_sel_d   = out_sel_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      err_flag_d  = err_flag_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end

      if (pop) begin
         rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
         cur_op_d    = head[EW-1 -: 3];
         cur_chain_d = head[2*W];
         num1_d      = head[2*W-1 -: W];
         num2_d      = head[W-1:0];
      end

      // The output mux keeps the previous op through LOAD (the persist
      // path feeds back the previous result) and switches entering EXEC.
      // A reserved op leaves the mux untouched.
      if (state_q == ST_LOAD && cur_op_q != OP_RSV) begin
         out_sel_d = op_onehot;
      end

      if (state_q == ST_EXEC) begin
         res_data_d = (cur_op_q == OP_RSV) ? '0 : alu_result;
         res_err_d  = (cur_op_q == OP_RSV) || (alu_ovf && cur_op_q == OP_MUL);
      end

      if (res_hs && res_err_q) begin
         err_flag_d = 1'b1;
      end
      if (state_q == ST_ERR && clr_err) begin
         err_flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cur_op_q    <= '0;
         cur_chain_q <= 1'b0;
         num1_q      <= '0;
         num2_q      <= '0;
         out_sel_q   <= 7'b0000001;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         err_flag_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cur_op_q    <= cur_op_d;
         cur_chain_q <= cur_chain_d;
         num1_q      <= num1_d;
         num2_q      <= num2_d;
         out_sel_q   <= out_sel_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         err_flag_q  <= err_flag_d;
      end
   end

   assign alu_out_sel = out_sel_q;
   assign alu_num1    = num1_q;
   assign alu_num2    = num2_q;
   assign res_data    = res_data_q;
   assign res_err     = res_err_q;
   assign err_flag    = err_flag_q;
   assign state       = state_q;

`ifdef ALU_SEQ_STATS_EN
   // ---------------------------------------------------------------------
   // Statistics counters, cleared by reset only
   // ---------------------------------------------------------------------
   logic [15:0] op_count_q, op_count_d;
   logic [7:0]  err_count_q, err_count_d;

   always_comb begin
      op_count_d  = op_count_q;
      err_count_d = err_count_q;
      if (res_hs) begin
         op_count_d = op_count_q + 16'd1;
         if (res_err_q && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         op_count_q  <= op_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign op_count  = op_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer with a small behavioural stand-in for the
// ALU datapath: operand registers that clear on the reset selector, load
// num1/num2 on the load selector, and on the persist selector take the
// accumulator from a result register (which tracks the output mux).
// Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
   localparam int W     = 8;
   localparam int DEPTH = 4;

   localparam logic [2:0] S_OFF  = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          on = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = 3'd0;
   logic          cmd_chain = 1'b0;
   logic [W-1:0]  cmd_a = '0;
   logic [W-1:0]  cmd_b = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [W-1:0]  res_data;
   logic          res_err;
   logic          err_flag;
   logic          clr_err = 1'b0;
   logic [2:0]    alu_in_sel;
   logic [6:0]    alu_out_sel;
   logic [W-1:0]  alu_num1;
   logic [W-1:0]  alu_num2;
   logic [W-1:0]  alu_result;
   logic          alu_ovf;
   logic [2:0]    state;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0]   op_count;
   logic [7:0]    err_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst(rst), .on(on),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .err_flag(err_flag), .clr_err(clr_err),
      .alu_in_sel(alu_in_sel), .alu_out_sel(alu_out_sel),
      .alu_num1(alu_num1), .alu_num2(alu_num2),
      .alu_result(alu_result), .alu_ovf(alu_ovf), .state(state)
`ifdef ALU_SEQ_STATS_EN
      , .op_count(op_count), .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- datapath stand-in ----------------
   logic [W-1:0]   dp_a_q, dp_b_q, dp_r_q, dp_y;
   logic [2*W-1:0] dp_prod;
   logic           dp_ovf;

   always_comb begin
      dp_prod = {{W{1'b0}}, dp_a_q} * {{W{1'b0}}, dp_b_q};
      dp_y    = '0;
      dp_ovf  = 1'b0;
      case (alu_out_sel)
         7'b0000001: dp_y = dp_a_q & dp_b_q;
         7'b0000010: dp_y = dp_a_q | dp_b_q;
         7'b0000100: dp_y = ~dp_a_q;
         7'b0001000: dp_y = dp_a_q ^ dp_b_q;
         7'b0010000: dp_y = dp_a_q + dp_b_q;
         7'b0100000: dp_y = dp_a_q - dp_b_q;
         7'b1000000: begin
            dp_y   = dp_prod[W-1:0];
            dp_ovf = |dp_prod[2*W-1:W];
         end
         default: dp_y = '0;
      endcase
   end

   always @(posedge clk) begin
      if (alu_in_sel == 3'b001) begin
         dp_a_q <= '0;
         dp_b_q <= '0;
         dp_r_q <= '0;
      end else if (alu_in_sel == 3'b010) begin
         dp_a_q <= alu_num1;
         dp_b_q <= alu_num2;
      end else if (alu_in_sel == 3'b100) begin
         dp_a_q <= dp_r_q;
         dp_b_q <= alu_num2;
         dp_r_q <= dp_y;
      end
   end

   assign alu_result = dp_y;
   assign alu_ovf    = dp_ovf;

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic chain,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      cmd_op    = op;
      cmd_chain = chain;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      check("push_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      $display("push  op=%0d chain=%0b a=0x%02h b=0x%02h", op, chain, a, b);
   endtask

   task automatic get_result(input string tag, input logic [W-1:0] exp_data,
                             input logic exp_err);
      int n;
      n = 0;
      while (!res_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_data"}, 32'(res_data), 32'(exp_data));
      check({tag, "_err"}, 32'(res_err), 32'(exp_err));
      $display("result %s data=0x%02h err=%0b", tag, res_data, res_err);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st);
      int n;
      n = 0;
      while (state != st && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(state), 32'(st));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset values
      rst = 1'b0;
      on  = 1'b0;
      repeat (3) tick();
      check("rst_state", 32'(state), 32'(S_OFF));
      check("rst_in_sel", 32'(alu_in_sel), 32'h1);
      check("rst_out_sel", 32'(alu_out_sel), 32'h1);
      check("rst_num1", 32'(alu_num1), 32'd0);
      check("rst_num2", 32'(alu_num2), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_res_err", 32'(res_err), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      on  = 1'b1;
      tick();
      check("on_idle", 32'(state), 32'(S_IDLE));

      // ADD 20+22, latency and selector sequence
      send(3'd4, 1'b0, 8'd20, 8'd22);
      check("add_t0_valid", 32'(res_valid), 32'd0);
      tick();
      check("add_load_state", 32'(state), 32'(S_LOAD));
      check("add_load_in_sel", 32'(alu_in_sel), 32'h2);
      check("add_load_num1", 32'(alu_num1), 32'd20);
      check("add_load_num2", 32'(alu_num2), 32'd22);
      tick();
      check("add_exec_state", 32'(state), 32'(S_EXEC));
      check("add_exec_in_sel", 32'(alu_in_sel), 32'h4);
      check("add_exec_out_sel", 32'(alu_out_sel), 32'h10);
      tick();
      check("add_t3_valid", 32'(res_valid), 32'd1);
      get_result("add", 8'd42, 1'b0);

      // SUB 5-7 then chained ADD +3
      send(3'd5, 1'b0, 8'd5, 8'd7);
      send(3'd4, 1'b1, 8'hAB, 8'd3);
      get_result("sub", 8'hFE, 1'b0);
      tick();
      check("chain_load_state", 32'(state), 32'(S_LOAD));
      check("chain_load_in_sel", 32'(alu_in_sel), 32'h4);
      get_result("chain_add", 8'h01, 1'b0);

      // MUL overflow -> ERR, queued command stalls until clr_err
      send(3'd6, 1'b0, 8'd16, 8'd16);
      send(3'd4, 1'b0, 8'd1, 8'd2);
      get_result("mul", 8'h00, 1'b1);
      check("mul_err_state", 32'(state), 32'(S_ERR));
      check("mul_err_flag", 32'(err_flag), 32'd1);
      repeat (4) tick();
      check("err_stall_state", 32'(state), 32'(S_ERR));
      check("err_stall_valid", 32'(res_valid), 32'd0);
      check("err_cmd_ready", 32'(cmd_ready), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_state", 32'(state), 32'(S_IDLE));
      check("clr_err_flag", 32'(err_flag), 32'd0);
      get_result("after_clr", 8'd3, 1'b0);

      // Reserved opcode
      send(3'd7, 1'b0, 8'd1, 8'd2);
      get_result("rsv", 8'h00, 1'b1);
      check("rsv_state", 32'(state), 32'(S_ERR));
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("rsv_clr_state", 32'(state), 32'(S_IDLE));

      // Fill the queue while the response is held
      for (int i = 1; i <= 5; i++) begin
         send(3'd4, 1'b0, 8'(10 * i), 8'(i));
         check($sformatf("fill_ready_%0d", i), 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
      end
      get_result("fill1", 8'd11, 1'b0);
      check("full_pop_state", 32'(state), 32'(S_IDLE));
      check("full_pop_ready", 32'(cmd_ready), 32'd0);
      tick();
      check("after_pop_ready", 32'(cmd_ready), 32'd1);
      get_result("fill2", 8'd22, 1'b0);
      get_result("fill3", 8'd33, 1'b0);
      get_result("fill4", 8'd44, 1'b0);
      get_result("fill5", 8'd55, 1'b0);

      // Reset during EXEC of AND
      send(3'd0, 1'b0, 8'hF0, 8'h3C);
      wait_state("and_exec", S_EXEC);
      rst = 1'b0;
      tick();
      check("mid_rst_state", 32'(state), 32'(S_OFF));
      check("mid_rst_valid", 32'(res_valid), 32'd0);
      check("mid_rst_in_sel", 32'(alu_in_sel), 32'h1);
      check("mid_rst_out_sel", 32'(alu_out_sel), 32'h1);
      check("mid_rst_num1", 32'(alu_num1), 32'd0);
      check("mid_rst_res_data", 32'(res_data), 32'd0);
      rst = 1'b1;
      tick();
      repeat (3) tick();
      check("post_rst_state", 32'(state), 32'(S_IDLE));
      check("post_rst_valid", 32'(res_valid), 32'd0);

      // Chain as first command after reset: accumulator is zero
      send(3'd4, 1'b1, 8'h77, 8'd5);
      get_result("first_chain", 8'd5, 1'b0);

      // on falls during LOAD: result delivered, then OFF with queue retained
      send(3'd3, 1'b0, 8'hAA, 8'hFF);
      send(3'd1, 1'b0, 8'h0F, 8'hF0);
      wait_state("xor_load", S_LOAD);
      on = 1'b0;
      get_result("xor", 8'h55, 1'b0);
      check("off_state", 32'(state), 32'(S_OFF));
      check("off_cmd_ready", 32'(cmd_ready), 32'd0);
      repeat (3) tick();
      check("off_hold_state", 32'(state), 32'(S_OFF));
      on = 1'b1;
      get_result("or_retained", 8'hFF, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
